// File: rtl/ram_loader.sv
// ram_loader: packs an upstream byte stream little-endian into RAM words.
// Define RAM_LOADER_CKSUM_EN to enable the running word checksum output.
module ram_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   word_count,
  input  logic                     abort,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   words_written,
  output logic [DATA_WIDTH-1:0]    checksum
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [ADDRESS_WIDTH:0]   count_q;
  logic [ADDRESS_WIDTH:0]   written_q;
  logic [IW-1:0]            idx_q;
  logic [DATA_WIDTH-1:0]    word_q;
  logic                     ready_q;
  logic                     wen_q;
  logic                     busy_q;
  logic                     done_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;

  logic                     accept;
  logic                     last_byte;
  logic                     launch;
  logic [DATA_WIDTH-1:0]    word_d;
  logic [ADDRESS_WIDTH:0]   written_d;
  logic [ADDRESS_WIDTH-1:0] addr_d;

  assign accept    = byte_valid && ready_q;
  assign last_byte = (idx_q == IW'(BYTES - 1));
  assign launch    = (state_q == S_IDLE) && start && !abort;
  assign written_d = written_q + (ADDRESS_WIDTH + 1)'(1);
  assign addr_d    = base_q + written_q[ADDRESS_WIDTH-1:0];

  // Byte k of the word lands in bits [8k+7:8k].
  always_comb begin
    word_d = word_q;
    for (int k = 0; k < BYTES; k++) begin
      if (idx_q == IW'(k)) begin
        word_d[8*k +: 8] = byte_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      written_q <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      ready_q   <= 1'b0;
      wen_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (launch) begin
            base_q    <= base_addr;
            count_q   <= word_count;
            written_q <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            busy_q    <= 1'b1;
            if (word_count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_COLLECT;
              ready_q <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (abort) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
          end else if (accept) begin
            if (last_byte) begin
              state_q <= S_WRITE;
              ready_q <= 1'b0;
              wen_q   <= 1'b1;
              addr_q  <= addr_d;
              data_q  <= word_d;
              idx_q   <= '0;
            end else begin
              idx_q  <= idx_q + IW'(1);
              word_q <= word_d;
            end
          end
        end
        S_WRITE: begin
          // The RAM samples this edge, so the word counts even on abort.
          wen_q     <= 1'b0;
          written_q <= written_d;
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (written_d == count_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_COLLECT;
            ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RAM_LOADER_CKSUM_EN
  logic [DATA_WIDTH-1:0] cksum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cksum_q <= '0;
    end else if (launch) begin
      cksum_q <= '0;
    end else if (wen_q) begin
      cksum_q <= cksum_q + data_q;
    end
  end

  assign checksum = cksum_q;
`else
  assign checksum = '0;
`endif

  assign byte_ready    = ready_q;
  assign ram_wEn       = wen_q;
  assign ram_addr      = addr_q;
  assign ram_dataIn    = data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_written = written_q;

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed and random loads checked each cycle against
// an event-level model of the loader's observable behaviour.
module tb_ram_loader;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int BYTES = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          abort = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready;
  logic          ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataIn;
  logic          busy;
  logic          done;
  logic [AW:0]   words_written;
  logic [DW-1:0] checksum;

  ram_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_addr(base_addr), .word_count(word_count),
    .abort(abort), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr),
    .ram_dataIn(ram_dataIn), .busy(busy), .done(done),
    .words_written(words_written), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = -1;
  int last_wen_cyc = -1;
  logic [AW+DW-1:0] wlog[$];
  logic [7:0] src[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit outs_nonzero();
    return byte_ready | ram_wEn | busy | done | (|ram_addr) |
           (|ram_dataIn) | (|words_written) | (|checksum);
  endfunction

  function automatic logic [7:0] next_byte();
    if (src.size() > 0) return src.pop_front();
    return 8'($urandom);
  endfunction

  // Observable-behaviour model: what each output must be this cycle.
  logic          m_busy = 0, m_ready = 0, m_wen = 0, m_done = 0;
  logic [AW-1:0] m_base = '0, m_addr = '0;
  logic [AW:0]   m_count = '0, m_cnt = '0;
  logic [DW-1:0] m_data = '0, m_sum = '0, m_word = '0;
  int            m_acc = 0;
  logic          wrote, d_was;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_zero", outs_nonzero(), 0);
      m_busy = 0; m_ready = 0; m_wen = 0; m_done = 0;
      m_addr = '0; m_data = '0; m_cnt = '0; m_sum = '0; m_acc = 0;
    end else begin
      chk("busy", busy, m_busy);
      chk("byte_ready", byte_ready, m_ready);
      chk("ram_wEn", ram_wEn, m_wen);
      chk("done", done, m_done);
      chk("ram_addr", ram_addr, m_addr);
      chk("ram_dataIn", ram_dataIn, m_data);
      chk("words_written", words_written, m_cnt);
`ifdef RAM_LOADER_CKSUM_EN
      chk("checksum", checksum, m_sum);
`else
      chk("checksum", checksum, 0);
`endif
      if (ram_wEn) begin
        wlog.push_back({ram_addr, ram_dataIn});
        last_wen_cyc = cyc;
      end
      if (done) done_cyc = cyc;
      wrote = m_wen;
      d_was = m_done;
      if (m_wen) begin
        m_cnt = m_cnt + 1;
        m_sum = m_sum + m_data;
      end
      m_wen = 0;
      m_done = 0;
      if (!m_busy) begin
        if (start && !abort) begin
          m_busy = 1; m_base = base_addr; m_count = word_count;
          m_cnt = 0; m_sum = 0; m_acc = 0;
          if (word_count == 0) m_done = 1;
          else m_ready = 1;
        end
      end else if (d_was || abort) begin
        m_busy = 0;
        m_ready = 0;
      end else if (wrote) begin
        if (m_cnt == m_count) m_done = 1;
        else m_ready = 1;
      end else if (m_ready && byte_valid) begin
        m_word[8*m_acc +: 8] = byte_data;
        m_acc++;
        if (m_acc == BYTES) begin
          m_ready = 0; m_wen = 1; m_acc = 0;
          m_addr = m_base + m_cnt[AW-1:0];
          m_data = m_word;
        end
      end
    end
  end

  task automatic async_rst();
    #2 reset_n = 1'b0;
    #1 chk("async_zero", outs_nonzero(), 0);
    start = 0; abort = 0; byte_valid = 0;
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // kill: 0 none, 1 abort at byte count, 2 reset at byte count,
  // 3 reset during a write, 4 abort at cycle index
  task automatic load(input logic [AW-1:0] b, input logic [AW:0] n,
                      input int vmode, input int kill, input int kill_at,
                      output int accepts);
    bit fin, acc, ab;
    logic [7:0] cur;
    accepts = 0;
    cur = next_byte();
    start = 1; base_addr = b; word_count = n;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 0; base_addr = AW'($urandom); word_count = (AW+1)'($urandom);
    fin = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      byte_data = cur;
      if (vmode == 0) byte_valid = 1;
      else if (vmode == 1) byte_valid = (c % 2 == 0);
      else byte_valid = ($urandom % 3 != 0);
      ab = (kill == 1 && accepts == kill_at) || (kill == 4 && c == kill_at);
      abort = ab;
      if (vmode == 2) start = busy && ($urandom % 8 == 0);
      if (kill == 2 && accepts == kill_at) begin
        async_rst();
        fin = 1;
      end else if (kill == 3 && ram_wEn) begin
        async_rst();
        fin = 1;
      end else begin
        @(negedge clk);
        acc = byte_valid && byte_ready;
        fin = done || ab;
        @(posedge clk);
        #1;
        if (acc) begin
          accepts++;
          cur = next_byte();
        end
      end
    end
    byte_valid = 0; abort = 0; start = 0;
    if (!fin) chk("load_timeout", 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int a;

  initial begin
    repeat (2) @(negedge clk);
    chk("init_zero", outs_nonzero(), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Two packed words back-to-back
    src = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    wlog.delete();
    load(12'h010, 2, 0, 0, 0, a);
    chk("t1_nwr", wlog.size(), 2);
    chk("t1_w0", wlog[0], {12'h010, 32'h44332211});
    chk("t1_w1", wlog[1], {12'h011, 32'h88776655});
    chk("t1_done_lat", done_cyc - last_wen_cyc, 1);
    chk("t1_ww", words_written, 2);
`ifdef RAM_LOADER_CKSUM_EN
    chk("t1_ck", checksum, 32'hCCAA8866);
`else
    chk("t1_ck", checksum, 0);
`endif
    chk("t1_idle", busy, 0);

    // Address wrap
    wlog.delete();
    load(12'hFFF, 2, 0, 0, 0, a);
    chk("t2_nwr", wlog.size(), 2);
    chk("t2_a0", wlog[0][AW+DW-1:DW], 12'hFFF);
    chk("t2_a1", wlog[1][AW+DW-1:DW], 12'h000);

    // Zero-length load
    wlog.delete();
    done_cyc = -1;
    load(12'h123, 0, 0, 0, 0, a);
    chk("t3_nwr", wlog.size(), 0);
    chk("t3_done_lat", done_cyc - start_cyc, 1);
    chk("t3_ww", words_written, 0);

    // Upstream valid every other cycle
    wlog.delete();
    load(12'h040, 1, 1, 0, 0, a);
    chk("t4_accepts", a, 4);
    chk("t4_nwr", wlog.size(), 1);

    // Abort two bytes into the second word
    wlog.delete();
    done_cyc = -1;
    load(12'h200, 3, 0, 1, 6, a);
    chk("t5_nwr", wlog.size(), 1);
    chk("t5_nodone", done_cyc, -1);
    chk("t5_ww", words_written, 1);
    chk("t5_idle", busy, 0);
    src = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
    wlog.delete();
    load(12'h300, 1, 0, 0, 0, a);
    chk("t5_reload", wlog[0], {12'h300, 32'hA3A2A1A0});

    // Reset mid-collect, then reset during a write
    load(12'h050, 2, 0, 2, 2, a);
    src = {8'h01, 8'h02, 8'h03, 8'h04};
    wlog.delete();
    load(12'h060, 1, 0, 0, 0, a);
    chk("t6_clean1", wlog[0], {12'h060, 32'h04030201});
    load(12'h070, 2, 0, 3, 0, a);
    src = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    wlog.delete();
    load(12'h080, 1, 0, 0, 0, a);
    chk("t6_clean2", wlog[0], {12'h080, 32'hEFBEADDE});
    chk("t6_ww", words_written, 1);

    // Random loads with gaps, aborts, resets and stray starts
    for (int i = 0; i < 60; i++) begin
      logic [AW:0] n;
      int kill;
      n = ($urandom % 8 == 0) ? '0 : (AW+1)'($urandom_range(1, 5));
      kill = ($urandom % 5 == 0) ? 4 : (($urandom % 10 == 0) ? 2 : 0);
      load(AW'($urandom), n, $urandom_range(0, 2), kill,
           $urandom_range(0, 20), a);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
